// File: rtl/titan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : titan_pkg
//  Description : Shared definitions for the Titan RV32I front end. Holds the
//                canonical NOP encoding, the fetch FSM state encoding, the
//                default reset vector and the fetch-queue entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package titan_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO of {pc, instruction} entries. Flush has
//                priority over push and pop. A push and a pop in the same
//                cycle on a full queue is legal: the written slot is the head
//                being consumed.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                i_push, i_data   - write an entry
//                i_pop            - discard head entry (caller ensures non-empty)
//                i_flush          - empty the queue
//                o_count          - number of valid entries
//                o_empty, o_head  - empty flag and head entry
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import titan_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  fetch_entry_t            i_data,
    input  logic                    i_pop,
    input  logic                    i_flush,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output fetch_entry_t            o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed behind r_count.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction fetch. Issues word reads (one outstanding),
//                queues returned words with their pc, presents them to ID with
//                valid/ready, and handles branch redirects by flushing the
//                queue and discarding any stale in-flight response.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                imem_addr/valid/ready      - memory request channel
//                imem_rdata/rvalid          - in-order memory response
//                branch_taken/target        - redirect from EX
//                instruction, pc, id_valid  - head entry to ID
//                id_ready                   - ID accepts head
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import titan_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR  = DEFAULT_RESET_ADDR,
    parameter int          QUEUE_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_valid,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        id_valid,
    input  logic        id_ready
);

    localparam int             CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0] c_DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);

    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    w_fetch_pc_nxt;
    logic [CNT_W-1:0] w_count;
    logic           w_empty;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic           w_accept;
    logic           w_room_idle;
    logic           w_room_wait;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;
    logic           w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = ^branch_target[1:0];

    assign w_pop = ~w_empty & id_ready;

    // In WAIT the response word occupies one slot, so issue only if a slot
    // remains after it lands, crediting a head consumed this same cycle.
    assign w_room_idle = {1'b0, w_count} < c_DEPTH_EXT;
    assign w_room_wait = ({1'b0, w_count} + (CNT_W + 1)'(1))
                       < (c_DEPTH_EXT + {{CNT_W{1'b0}}, w_pop});

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_issue = w_room_idle & ~branch_taken;
                if (w_issue && imem_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (branch_taken) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_issue     = w_room_wait;
                        w_state_nxt = (w_issue && imem_ready) ? ST_WAIT : ST_IDLE;
                    end
                end else if (branch_taken) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // The stale response retires the outstanding request even if
                // another redirect lands in the same cycle.
                if (imem_rvalid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gate with rst_n so no request is visible while reset is held.
    assign imem_valid = w_issue & rst_n;
    assign imem_addr  = r_fetch_pc;
    assign w_accept   = imem_valid & imem_ready;

    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (branch_taken)  w_fetch_pc_nxt = {branch_target[31:2], 2'b00};
        else if (w_accept) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_ADDR;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // The outstanding request was for fetch_pc - 4: fetch_pc advanced on accept.
    assign w_push_entry = '{pc: r_fetch_pc - 32'd4, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (branch_taken),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign id_valid    = ~w_empty;
    assign instruction = w_empty ? NOP_INSTR : w_head.instr;
    assign pc          = w_empty ? 32'h0000_0000 : w_head.pc;

endmodule
`default_nettype wire
